// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix-keypad front end.
// Drives one keypad column at a time and samples the synchronised row
// returns once per column dwell. Each sample is debounced, and every press
// that is accepted becomes one ASCII code in a small output queue. Codes are
// not repeated while a key is held.
//
// Parameters:
//   SCAN_DIV      clock cycles each column is driven (4..65535)
//   DEBOUNCE_CNT  consecutive matching samples needed to accept a press or
//                 a release (1..15)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset, clears all state
//   rows[3:0]    keypad row returns, active-high, asynchronous to clk
//   cols[3:0]    one-hot active-high column drive
//   rdEn         one-cycle pop strobe
//   keyCode[7:0] ASCII code at the queue head, 8'd0 when empty
//   keyValid     queue not empty
//   overflow     sticky flag: a press was dropped because the queue was full
//   clrOverflow  clears overflow (a new overflow in the same cycle wins)
//
// Build option:
//   KEYPAD_FIFO_EN  defined: 4-entry circular FIFO.
//                   undefined: single holding register.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  input  logic       rdEn,
  output logic [7:0] keyCode,
  output logic       keyValid,
  output logic       overflow,
  input  logic       clrOverflow
);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_TARGET  = 4'(DEBOUNCE_CNT);

  // ASCII for the label at index 4*row+col of "123A456B789C*0#D".
  function automatic logic [7:0] ascii_of(input logic [3:0] idx);
    logic [7:0] code;
    case (idx)
      4'd0:    code = 8'h31;
      4'd1:    code = 8'h32;
      4'd2:    code = 8'h33;
      4'd3:    code = 8'h41;
      4'd4:    code = 8'h34;
      4'd5:    code = 8'h35;
      4'd6:    code = 8'h36;
      4'd7:    code = 8'h42;
      4'd8:    code = 8'h37;
      4'd9:    code = 8'h38;
      4'd10:   code = 8'h39;
      4'd11:   code = 8'h43;
      4'd12:   code = 8'h2A;
      4'd13:   code = 8'h30;
      4'd14:   code = 8'h23;
      4'd15:   code = 8'h44;
      default: code = 8'h00;
    endcase
    return code;
  endfunction

  // Lowest active row wins when several rows are high.
  function automatic logic [1:0] lowest_row(input logic [3:0] r);
    logic [1:0] idx;
    if (r[0]) begin
      idx = 2'd0;
    end else if (r[1]) begin
      idx = 2'd1;
    end else if (r[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  logic [3:0]  sync1_r;
  logic [3:0]  rows_s_r;
  logic [15:0] dwell_r;
  logic [1:0]  col_r;
  logic [3:0]  cols_r;
  state_t      state_r;
  logic [3:0]  pattern_r;
  logic [3:0]  match_cnt_r;
  logic [3:0]  rel_cnt_r;
  logic        sample_s;
  logic        push_s;
  logic [7:0]  push_code_s;
  logic        pop_s;
  logic        full_s;
  logic        wr_s;
  logic        ovf_set_s;
  logic [7:0]  key_code_r;
  logic        key_valid_r;
  logic        overflow_r;

  assign sample_s = (dwell_r == DWELL_LAST);

  // Two-flop synchroniser for the asynchronous row returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r  <= 4'd0;
      rows_s_r <= 4'd0;
    end else begin
      sync1_r  <= rows;
      rows_s_r <= sync1_r;
    end
  end

  // Accepting sample: the one that completes DEBOUNCE_CNT matches.
  always_comb begin
    push_s      = 1'b0;
    push_code_s = ascii_of({lowest_row(rows_s_r), col_r});
    if (sample_s) begin
      case (state_r)
        ST_SCAN: begin
          if ((rows_s_r != 4'd0) && (DB_TARGET == 4'd1)) begin
            push_s = 1'b1;
          end else begin
            push_s = 1'b0;
          end
        end
        ST_DEBOUNCE: begin
          if ((rows_s_r == pattern_r) && ((match_cnt_r + 4'd1) == DB_TARGET)) begin
            push_s = 1'b1;
          end else begin
            push_s = 1'b0;
          end
        end
        default: push_s = 1'b0;
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  // Dwell counter, column drive and scan/debounce/hold state machine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_r     <= 16'd0;
      col_r       <= 2'd0;
      cols_r      <= 4'b0001;
      state_r     <= ST_SCAN;
      pattern_r   <= 4'd0;
      match_cnt_r <= 4'd0;
      rel_cnt_r   <= 4'd0;
    end else begin
      if (sample_s) begin
        dwell_r <= 16'd0;
        case (state_r)
          ST_SCAN: begin
            if (rows_s_r == 4'd0) begin
              col_r  <= col_r + 2'd1;
              cols_r <= {cols_r[2:0], cols_r[3]};
            end else begin
              pattern_r   <= rows_s_r;
              match_cnt_r <= 4'd1;
              rel_cnt_r   <= 4'd0;
              state_r     <= push_s ? ST_HELD : ST_DEBOUNCE;
            end
          end
          ST_DEBOUNCE: begin
            if (rows_s_r == pattern_r) begin
              match_cnt_r <= match_cnt_r + 4'd1;
              rel_cnt_r   <= 4'd0;
              state_r     <= push_s ? ST_HELD : ST_DEBOUNCE;
            end else begin
              col_r   <= col_r + 2'd1;
              cols_r  <= {cols_r[2:0], cols_r[3]};
              state_r <= ST_SCAN;
            end
          end
          ST_HELD: begin
            if (rows_s_r != 4'd0) begin
              rel_cnt_r <= 4'd0;
            end else if ((rel_cnt_r + 4'd1) == DB_TARGET) begin
              rel_cnt_r <= 4'd0;
              col_r     <= col_r + 2'd1;
              cols_r    <= {cols_r[2:0], cols_r[3]};
              state_r   <= ST_SCAN;
            end else begin
              rel_cnt_r <= rel_cnt_r + 4'd1;
            end
          end
          default: state_r <= ST_SCAN;
        endcase
      end else begin
        dwell_r <= dwell_r + 16'd1;
      end
    end
  end

  // A push into a full queue still lands if a pop frees a slot that cycle.
  assign wr_s      = push_s & (~full_s | pop_s);
  assign ovf_set_s = push_s & full_s & ~pop_s;

`ifdef KEYPAD_FIFO_EN
  logic [7:0] mem_r   [4];
  logic [7:0] mem_n_s [4];
  logic [1:0] wr_ptr_r;
  logic [1:0] rd_ptr_r;
  logic [2:0] count_r;
  logic [1:0] wr_ptr_n_s;
  logic [1:0] rd_ptr_n_s;
  logic [2:0] count_n_s;

  assign full_s = (count_r == 3'd4);
  assign pop_s  = rdEn & (count_r != 3'd0);

  // Next FIFO contents, pointers and occupancy.
  always_comb begin
    mem_n_s = mem_r;
    if (wr_s) begin
      mem_n_s[wr_ptr_r] = push_code_s;
      wr_ptr_n_s        = wr_ptr_r + 2'd1;
    end else begin
      wr_ptr_n_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_n_s = rd_ptr_r + 2'd1;
    end else begin
      rd_ptr_n_s = rd_ptr_r;
    end
    case ({wr_s, pop_s})
      2'b10:   count_n_s = count_r + 3'd1;
      2'b01:   count_n_s = count_r - 3'd1;
      default: count_n_s = count_r;
    endcase
  end

  // FIFO state plus registered head/valid outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mem_r[i] <= 8'd0;
      end
      wr_ptr_r    <= 2'd0;
      rd_ptr_r    <= 2'd0;
      count_r     <= 3'd0;
      key_valid_r <= 1'b0;
      key_code_r  <= 8'd0;
    end else begin
      mem_r       <= mem_n_s;
      wr_ptr_r    <= wr_ptr_n_s;
      rd_ptr_r    <= rd_ptr_n_s;
      count_r     <= count_n_s;
      key_valid_r <= (count_n_s != 3'd0);
      key_code_r  <= (count_n_s != 3'd0) ? mem_n_s[rd_ptr_n_s] : 8'd0;
    end
  end
`else
  logic [7:0] hold_r;
  logic       valid_r;

  assign full_s = valid_r;
  assign pop_s  = rdEn & valid_r;

  // Single holding register plus registered head/valid outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_r      <= 8'd0;
      valid_r     <= 1'b0;
      key_valid_r <= 1'b0;
      key_code_r  <= 8'd0;
    end else if (wr_s) begin
      hold_r      <= push_code_s;
      valid_r     <= 1'b1;
      key_valid_r <= 1'b1;
      key_code_r  <= push_code_s;
    end else if (pop_s) begin
      valid_r     <= 1'b0;
      key_valid_r <= 1'b0;
      key_code_r  <= 8'd0;
    end else begin
      valid_r     <= valid_r;
      key_valid_r <= valid_r;
      key_code_r  <= valid_r ? hold_r : 8'd0;
    end
  end
`endif

  // Sticky overflow; a new drop outranks a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (ovf_set_s) begin
      overflow_r <= 1'b1;
    end else if (clrOverflow) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign cols     = cols_r;
  assign keyCode  = key_code_r;
  assign keyValid = key_valid_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=2).
// Expectations follow KEYPAD_FIFO_EN when the macro is defined.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       rdEn;
  logic [7:0] keyCode;
  logic       keyValid;
  logic       overflow;
  logic       clrOverflow;

  int vectors;
  int miscompares;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(2)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols), .rdEn(rdEn),
    .keyCode(keyCode), .keyValid(keyValid), .overflow(overflow),
    .clrOverflow(clrOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r;
    int         c;
    logic [7:0] code;
  } press_vec_t;

  press_vec_t tbl [10];
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Wait for the negedge just after cols switches to column c.
  task automatic wait_fresh_col(input int c);
    logic [3:0] target;
    logic [3:0] prev;
    int n;
    target = 4'(4'b0001 << c);
    prev = cols;
    n = 0;
    @(negedge clk);
    while (!((cols == target) && (prev != target)) && (n < 200)) begin
      prev = cols;
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("wait_fresh_col");
  endtask

  task automatic wait_leave_col(input int c);
    logic [3:0] target;
    int n;
    target = 4'(4'b0001 << c);
    n = 0;
    while ((cols == target) && (n < 60)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) timeout("wait_leave_col");
  endtask

  // Full press: rdEn/clrOverflow optionally land on the accepting edge.
  task automatic press(input logic [3:0] r, input int c, input bit pop_acc, input bit clr_acc);
    wait_fresh_col(c);
    rows = r;
    repeat (7) @(negedge clk);
    rdEn = pop_acc;
    clrOverflow = clr_acc;
    @(negedge clk);
    rdEn = 1'b0;
    clrOverflow = 1'b0;
    repeat (4) @(negedge clk);
    rows = 4'd0;
    wait_leave_col(c);
  endtask

  task automatic pop_one();
    rdEn = 1'b1;
    @(negedge clk);
    rdEn = 1'b0;
  endtask

  task automatic drain_check(input string name);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({name, "_head"}, 32'(keyCode), 32'(exp_q[i]));
      chk({name, "_valid"}, 32'(keyValid), 32'd1);
      pop_one();
    end
    chk({name, "_empty"}, 32'(keyValid), 32'd0);
    chk({name, "_zero"}, 32'(keyCode), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vectors = 0;
    miscompares = 0;
    tbl[0] = '{4'b1000, 1, 8'h30};
    tbl[1] = '{4'b1000, 3, 8'h44};
    tbl[2] = '{4'b1010, 3, 8'h42};
    tbl[3] = '{4'b0100, 0, 8'h37};
    tbl[4] = '{4'b1100, 2, 8'h39};
    tbl[5] = '{4'b0010, 2, 8'h36};
    tbl[6] = '{4'b1000, 0, 8'h2A};
    tbl[7] = '{4'b1000, 2, 8'h23};
    tbl[8] = '{4'b0011, 0, 8'h31};
    tbl[9] = '{4'b0100, 3, 8'h43};

    reset = 1'b1;
    rows = 4'd0;
    rdEn = 1'b0;
    clrOverflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cols", 32'(cols), 32'h1);
    chk("rst_valid", 32'(keyValid), 32'd0);
    chk("rst_code", 32'(keyCode), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Column stepping every 4 cycles after reset release.
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("step_%0d", k), 32'(cols), 32'(4'b0001 << ((k / 4) % 4)));
    end

    // Single press '2' with exact acceptance and release timing.
    wait_fresh_col(1);
    rows = 4'b0001;
    repeat (7) @(negedge clk);
    chk("press_early", 32'(keyValid), 32'd0);
    @(negedge clk);
    chk("press_valid", 32'(keyValid), 32'd1);
    chk("press_code", 32'(keyCode), 32'h32);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (cols != 4'b0010) bad++;
    end
    chk("press_frozen", 32'(bad), 32'd0);
    rows = 4'd0;
    repeat (7) @(negedge clk);
    chk("release_hold", 32'(cols), 32'h2);
    @(negedge clk);
    chk("release_adv", 32'(cols), 32'h4);
    chk("single_code", 32'(keyCode), 32'h32);
    pop_one();
    chk("pop_valid", 32'(keyValid), 32'd0);
    chk("pop_code", 32'(keyCode), 32'd0);
    pop_one();
    @(negedge clk);
    chk("empty_pop", 32'(keyValid), 32'd0);

    // Reset asserted mid-hold clears outputs immediately.
    wait_fresh_col(1);
    rows = 4'b0010;
    repeat (10) @(negedge clk);
    chk("hold_valid", 32'(keyValid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_cols", 32'(cols), 32'h1);
    chk("async_valid", 32'(keyValid), 32'd0);
    chk("async_code", 32'(keyCode), 32'd0);
    rows = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("hold_rst_nopush", 32'(keyValid), 32'd0);

    // Reset mid-debounce drops the pending press.
    wait_fresh_col(1);
    rows = 4'b0001;
    repeat (6) @(negedge clk);
    #2;
    reset = 1'b1;
    rows = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("deb_rst_nopush", 32'(keyValid), 32'd0);

    // Bounce: one nonzero sample, then scanning resumes at next column.
    wait_fresh_col(2);
    rows = 4'b0100;
    repeat (4) @(negedge clk);
    rows = 4'd0;
    repeat (3) @(negedge clk);
    chk("bounce_held", 32'(cols), 32'h4);
    @(negedge clk);
    chk("bounce_adv", 32'(cols), 32'h8);
    chk("bounce_nopush", 32'(keyValid), 32'd0);

    // Key map table.
    for (int i = 0; i < 10; i++) begin
      press(tbl[i].r, tbl[i].c, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_valid", i), 32'(keyValid), 32'd1);
      chk($sformatf("tbl%0d_code", i), 32'(keyCode), 32'(tbl[i].code));
      pop_one();
      chk($sformatf("tbl%0d_pop", i), 32'(keyValid), 32'd0);
    end

    // Overflow: '1','2','3','A' then '4'.
    press(4'b0001, 0, 1'b0, 1'b0);
    press(4'b0001, 1, 1'b0, 1'b0);
    press(4'b0001, 2, 1'b0, 1'b0);
    press(4'b0001, 3, 1'b0, 1'b0);
`ifdef KEYPAD_FIFO_EN
    chk("ovf_after4", 32'(overflow), 32'd0);
`else
    chk("ovf_after4", 32'(overflow), 32'd1);
`endif
    press(4'b0010, 0, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(keyCode), 32'h31);
    press(4'b0010, 1, 1'b0, 1'b1);
    chk("ovf_clr_race", 32'(overflow), 32'd1);
    clrOverflow = 1'b1;
    @(negedge clk);
    clrOverflow = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
`ifdef KEYPAD_FIFO_EN
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h41};
`else
    exp_q = '{8'h31};
`endif
    drain_check("ovf_drain");

    // Full queue with a pop on the accepting edge of '5'.
    press(4'b0001, 0, 1'b0, 1'b0);
    press(4'b0001, 1, 1'b0, 1'b0);
    press(4'b0001, 2, 1'b0, 1'b0);
    press(4'b0001, 3, 1'b0, 1'b0);
    clrOverflow = 1'b1;
    @(negedge clk);
    clrOverflow = 1'b0;
    chk("fullpop_pre", 32'(overflow), 32'd0);
    press(4'b0010, 1, 1'b1, 1'b0);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
`ifdef KEYPAD_FIFO_EN
    exp_q = '{8'h32, 8'h33, 8'h41, 8'h35};
`else
    exp_q = '{8'h35};
`endif
    drain_check("fullpop_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
